// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store execution unit.
//   - Bus widths for data, tag, register name and opcode.
//   - Opcode encodings for the eight memory operations.
//   - FSM state encodings and the idle ("free") values of the result bus.
//   - Small decode helpers used by the unit.
package load_store_unit_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned TagW  = 4;
  localparam int unsigned NameW = 5;
  localparam int unsigned OpW   = 4;

  // Opcode encodings; 0 and 9..15 are unused and treated as unknown.
  typedef enum logic [OpW-1:0] {
    OpNone = 4'd0,
    OpLB   = 4'd1,
    OpLH   = 4'd2,
    OpLW   = 4'd3,
    OpLBU  = 4'd4,
    OpLHU  = 4'd5,
    OpSB   = 4'd6,
    OpSH   = 4'd7,
    OpSW   = 4'd8
  } ls_op_e;

  typedef enum logic [1:0] {
    LSidle   = 2'd0,
    LSaccess = 2'd1,
    LSdone   = 2'd2
  } ls_state_e;

  // Values driven on the result bus when nothing is being broadcast.
  localparam logic [TagW-1:0]  TagFree  = '0;
  localparam logic [NameW-1:0] NameFree = '0;
  localparam logic [DataW-1:0] DataFree = '0;

  function automatic logic op_is_load(input ls_op_e op);
    logic res;
    case (op)
      OpLB, OpLH, OpLW, OpLBU, OpLHU: res = 1'b1;
      default:                        res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic op_is_store(input ls_op_e op);
    logic res;
    case (op)
      OpSB, OpSH, OpSW: res = 1'b1;
      default:          res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic op_is_valid(input ls_op_e op);
    return op_is_load(op) || op_is_store(op);
  endfunction

  // Number of bytes transferred by an operation (1, 2 or 4).
  function automatic logic [2:0] op_num_bytes(input ls_op_e op);
    logic [2:0] res;
    case (op)
      OpLB, OpLBU, OpSB: res = 3'd1;
      OpLH, OpLHU, OpSH: res = 3'd2;
      OpLW, OpSW:        res = 3'd4;
      default:           res = 3'd1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/load_store_unit.sv
// Load/store execution unit.
// Accepts one memory operation at a time from the load/store buffer, forms the
// effective address (operandO + imm), and performs the access byte-serially,
// little-endian, over an 8-bit request/acknowledge memory port. Loads broadcast
// their sign- or zero-extended result on the common data bus for one cycle.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   LSworkEn              issue strobe from the buffer
//   operandO/operandT/imm base address, store data, address offset
//   wrtTag/wrtName/opCode destination tag, register name, operation
//   LSreadEn              unit can accept an issue (combinational)
//   enLSwrt/LStag/LSname/LSdata  registered result broadcast
//   memEn/memWr/memAddr/memWdata byte request (combinational from state)
//   memRdata/memAck       read byte and acknowledge from memory
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             LSworkEn,
  input  logic [DataW-1:0] operandO,
  input  logic [DataW-1:0] operandT,
  input  logic [DataW-1:0] imm,
  input  logic [TagW-1:0]  wrtTag,
  input  logic [NameW-1:0] wrtName,
  input  logic [OpW-1:0]   opCode,
  output logic             LSreadEn,
  output logic             enLSwrt,
  output logic [TagW-1:0]  LStag,
  output logic [NameW-1:0] LSname,
  output logic [DataW-1:0] LSdata,
  output logic             memEn,
  output logic             memWr,
  output logic [31:0]      memAddr,
  output logic [7:0]       memWdata,
  input  logic [7:0]       memRdata,
  input  logic             memAck
);

  ls_state_e        state_q, state_d;
  ls_op_e           op_q, op_d;
  logic [TagW-1:0]  tag_q, tag_d;
  logic [NameW-1:0] name_q, name_d;
  logic [31:0]      addr_q, addr_d;
  logic [DataW-1:0] sdata_q, sdata_d;
  logic [DataW-1:0] rdata_q, rdata_d;
  logic [2:0]       num_q, num_d;
  logic [1:0]       idx_q, idx_d;

  logic             en_wrt_q;
  logic [TagW-1:0]  ls_tag_q;
  logic [NameW-1:0] ls_name_q;
  logic [DataW-1:0] ls_data_q;

  ls_op_e           op_in;
  logic             last_byte;
  logic             bcast;
  logic [DataW-1:0] load_ext;

  assign op_in     = ls_op_e'(opCode);
  assign last_byte = ({1'b0, idx_q} == (num_q - 3'd1));

  // The result is broadcast in DONE, so it is registered on the edge that
  // completes the final byte of a load.
  assign bcast = (state_q == LSaccess) && memAck && last_byte && op_is_load(op_q);

  // Next-state, capture and memory request decode.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    tag_d    = tag_q;
    name_d   = name_q;
    addr_d   = addr_q;
    sdata_d  = sdata_q;
    rdata_d  = rdata_q;
    num_d    = num_q;
    idx_d    = idx_q;
    LSreadEn = 1'b0;
    memEn    = 1'b0;
    memWr    = 1'b0;
    memAddr  = '0;
    memWdata = '0;

    unique case (state_q)
      LSidle: begin
        // Dropping ready in the strobe cycle keeps a second issue out.
        LSreadEn = !LSworkEn;
        if (LSworkEn) begin
          op_d    = op_in;
          tag_d   = wrtTag;
          name_d  = wrtName;
          addr_d  = operandO + imm;
          sdata_d = operandT;
          rdata_d = '0;
          num_d   = op_num_bytes(op_in);
          idx_d   = '0;
          // Unknown opcodes skip the access and finish silently.
          state_d = op_is_valid(op_in) ? LSaccess : LSdone;
        end
      end
      LSaccess: begin
        memEn    = 1'b1;
        memWr    = op_is_store(op_q);
        memAddr  = addr_q + {30'd0, idx_q};
        memWdata = sdata_q[{idx_q, 3'b000} +: 8];
        if (memAck) begin
          if (op_is_load(op_q)) begin
            rdata_d[{idx_q, 3'b000} +: 8] = memRdata;
          end
          idx_d = idx_q + 2'd1;
          if (last_byte) begin
            state_d = LSdone;
          end
        end
      end
      LSdone: begin
        state_d = LSidle;
      end
      default: begin
        state_d = LSidle;
      end
    endcase
  end

  // Sign/zero extension of the assembled load bytes.
  always_comb begin
    load_ext = rdata_d;
    case (op_q)
      OpLB:    load_ext = {{24{rdata_d[7]}}, rdata_d[7:0]};
      OpLH:    load_ext = {{16{rdata_d[15]}}, rdata_d[15:0]};
      OpLBU:   load_ext = {24'd0, rdata_d[7:0]};
      OpLHU:   load_ext = {16'd0, rdata_d[15:0]};
      default: load_ext = rdata_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LSidle;
      op_q      <= OpNone;
      tag_q     <= TagFree;
      name_q    <= NameFree;
      addr_q    <= '0;
      sdata_q   <= '0;
      rdata_q   <= '0;
      num_q     <= 3'd1;
      idx_q     <= '0;
      en_wrt_q  <= 1'b0;
      ls_tag_q  <= TagFree;
      ls_name_q <= NameFree;
      ls_data_q <= DataFree;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      name_q    <= name_d;
      addr_q    <= addr_d;
      sdata_q   <= sdata_d;
      rdata_q   <= rdata_d;
      num_q     <= num_d;
      idx_q     <= idx_d;
      en_wrt_q  <= bcast;
      ls_tag_q  <= bcast ? tag_q : TagFree;
      ls_name_q <= bcast ? name_q : NameFree;
      ls_data_q <= bcast ? load_ext : DataFree;
    end
  end

  assign enLSwrt = en_wrt_q;
  assign LStag   = ls_tag_q;
  assign LSname  = ls_name_q;
  assign LSdata  = ls_data_q;

endmodule
